// File: rtl/flash_boot_pkg.sv
// flash_boot_pkg: shared definitions for the SPI NOR boot loader.
//   state_t        boot FSM states
//   CMD_READ       0x03 single-bit READ opcode
//   CMD_FAST_READ  0x0B FAST_READ opcode (used with FLASH_BOOT_FAST_READ_EN)
//   DUMMY_CYCLES   SCK cycles inserted after the address for FAST_READ
//   byte_swap32    converts flash byte order into a little-endian RAM word
package flash_boot_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CS_SETUP,
        ST_CMD,
        ST_ADDR,
        ST_DUMMY,
        ST_DATA,
        ST_WRITE,
        ST_CS_HOLD,
        ST_CS_HIGH,
        ST_DONE
    } state_t;

    localparam logic [7:0]  CMD_READ      = 8'h03;
    localparam logic [7:0]  CMD_FAST_READ = 8'h0B;
    localparam int unsigned DUMMY_CYCLES  = 8;

    // The first flash byte of a word is shifted in first and so ends up in
    // the top byte of the shift register; the RAM wants it in bits [7:0].
    function automatic logic [31:0] byte_swap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/flash_boot_sck_gen.sv
// flash_boot_sck_gen: SPI mode-0 SCK generator with edge strobes.
//   clk, rst_n  system clock, async active-low reset
//   en          run enable; when low the divider and SCK are held at 0
//   sck         SCK level (idles low)
//   rise_en     one-cycle strobe in the clk cycle whose edge raises SCK
//   fall_en     one-cycle strobe in the clk cycle whose edge lowers SCK
// CLK_DIV is the SCK half-period in clk cycles (>= 1).
module flash_boot_sck_gen
    import flash_boot_pkg::*;
#(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic sck,
    output logic rise_en,
    output logic fall_en
);

    localparam int unsigned   CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;
    logic          tick;

    assign tick    = en && (cnt == LAST);
    assign rise_en = tick && !sck;
    assign fall_en = tick && sck;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            sck <= 1'b0;
        end else if (!en) begin
            cnt <= '0;
            sck <= 1'b0;
        end else if (tick) begin
            cnt <= '0;
            sck <= ~sck;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/flash_boot_loader.sv
// flash_boot_loader: copies len_i 32-bit words from SPI NOR flash (single-bit
// READ, or FAST_READ when FLASH_BOOT_FAST_READ_EN is defined) into RAM.
//   clk, rst_n                    system clock, async active-low reset
//   start_i                       start pulse, sampled only in IDLE
//   src_addr_i/dst_addr_i/len_i   flash byte address, RAM byte address, words
//   busy_o, done_o                transfer in progress, completion pulse
//   spi_clk_o/csn_o/sdo_o/sdi_i   flash pins (mode 0)
//   mem_req_o/addr_o/wdata_o/gnt_i RAM write port, write accepted on req&gnt
// Macro: FLASH_BOOT_FAST_READ_EN selects opcode 0x0B plus 8 dummy SCK cycles.
module flash_boot_loader
    import flash_boot_pkg::*;
#(
    parameter int unsigned CLK_DIV = 2,
    parameter int unsigned LEN_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [23:0]      src_addr_i,
    input  logic [31:0]      dst_addr_i,
    input  logic [LEN_W-1:0] len_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             spi_clk_o,
    output logic             spi_csn_o,
    output logic             spi_sdo_o,
    input  logic             spi_sdi_i,
    output logic             mem_req_o,
    output logic [31:0]      mem_addr_o,
    output logic [31:0]      mem_wdata_o,
    input  logic             mem_gnt_i
);

`ifdef FLASH_BOOT_FAST_READ_EN
    localparam logic [7:0] READ_CMD   = CMD_FAST_READ;
    localparam state_t     AFTER_ADDR = ST_DUMMY;
`else
    localparam logic [7:0] READ_CMD   = CMD_READ;
    localparam state_t     AFTER_ADDR = ST_DATA;
`endif

    localparam int unsigned GW = $clog2(2 * CLK_DIV) + 1;

    state_t            state, next_state;
    logic              sck_en, rise_en, fall_en, start_ok;
    logic [31:0]       sout, sin, dst;
    logic [4:0]        bit_cnt;
    logic [LEN_W-1:0]  words;
    logic [GW-1:0]     gap_cnt;

    flash_boot_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (sck_en),
        .sck     (spi_clk_o),
        .rise_en (rise_en),
        .fall_en (fall_en)
    );

    assign start_ok   = (state == ST_IDLE) && start_i;
    assign spi_sdo_o  = sout[31];
    assign mem_addr_o = dst;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= next_state;
    end

    // CMD and ADDR share one 32-bit shift-out word, so bit_cnt runs 0..31
    // across both and wraps to 0 on its own when ADDR ends.
    always_comb begin
        next_state = state;
        sck_en     = 1'b0;
        unique case (state)
            ST_IDLE:     if (start_i) next_state = (len_i == '0) ? ST_DONE : ST_CS_SETUP;
            ST_CS_SETUP: begin
                sck_en = 1'b1;
                if (rise_en) next_state = ST_CMD;
            end
            ST_CMD: begin
                sck_en = 1'b1;
                if (fall_en && bit_cnt == 5'd7) next_state = ST_ADDR;
            end
            ST_ADDR: begin
                sck_en = 1'b1;
                if (fall_en && bit_cnt == 5'd31) next_state = AFTER_ADDR;
            end
            ST_DUMMY: begin
                sck_en = 1'b1;
                if (fall_en && bit_cnt == 5'(DUMMY_CYCLES - 1)) next_state = ST_DATA;
            end
            ST_DATA: begin
                sck_en = 1'b1;
                if (fall_en && bit_cnt == 5'd31) next_state = ST_WRITE;
            end
            ST_WRITE:    if (mem_gnt_i) next_state = (words == LEN_W'(1)) ? ST_CS_HOLD : ST_DATA;
            ST_CS_HOLD:  if (gap_cnt == GW'(CLK_DIV - 1)) next_state = ST_CS_HIGH;
            ST_CS_HIGH:  if (gap_cnt == GW'(2 * CLK_DIV - 1)) next_state = ST_DONE;
            ST_DONE:     next_state = ST_IDLE;
            default:     next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sout        <= '0;
            sin         <= '0;
            dst         <= '0;
            bit_cnt     <= '0;
            words       <= '0;
            gap_cnt     <= '0;
            mem_wdata_o <= '0;
            mem_req_o   <= 1'b0;
            spi_csn_o   <= 1'b1;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
        end else begin
            if (start_ok) begin
                sout    <= {READ_CMD, src_addr_i};
                dst     <= dst_addr_i;
                words   <= len_i;
                bit_cnt <= '0;
            end
            if (fall_en) begin
                sout    <= {sout[30:0], 1'b0};
                bit_cnt <= (state == ST_DUMMY && next_state == ST_DATA) ? '0 : bit_cnt + 5'd1;
            end
            if (rise_en && state == ST_DATA) sin <= {sin[30:0], spi_sdi_i};
            if (state == ST_DATA && next_state == ST_WRITE) mem_wdata_o <= byte_swap32(sin);
            if (state == ST_WRITE && mem_gnt_i) begin
                dst   <= dst + 32'd4;
                words <= words - LEN_W'(1);
            end
            gap_cnt <= ((state == ST_CS_HOLD || state == ST_CS_HIGH) && next_state == state)
                       ? gap_cnt + GW'(1) : '0;
            // Pins and handshake are registered from next_state so they are
            // glitch-free yet line up with the state they belong to.
            spi_csn_o <= !(next_state inside {ST_CS_SETUP, ST_CMD, ST_ADDR, ST_DUMMY,
                                              ST_DATA, ST_WRITE, ST_CS_HOLD});
            mem_req_o <= (next_state == ST_WRITE);
            busy_o    <= (state == ST_IDLE) ? start_i : (state != ST_DONE);
            done_o    <= (state == ST_DONE);
        end
    end

endmodule

// File: tb/tb_flash_boot_loader.sv
module tb_flash_boot_loader;

`ifdef FLASH_BOOT_FAST_READ_EN
    localparam logic [7:0]  EXP_CMD = 8'h0B;
    localparam int unsigned DUMMY   = 8;
`else
    localparam logic [7:0]  EXP_CMD = 8'h03;
    localparam int unsigned DUMMY   = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_i = 1'b0;
    logic [23:0] src_addr_i = '0;
    logic [31:0] dst_addr_i = '0;
    logic [15:0] len_i = '0;
    logic        busy_o, done_o, spi_clk_o, spi_csn_o, spi_sdo_o;
    logic        spi_sdi_i = 1'b0;
    logic        mem_req_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic        mem_gnt_i = 1'b1;

    flash_boot_loader #(.CLK_DIV(2), .LEN_W(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start_i),
        .src_addr_i  (src_addr_i),
        .dst_addr_i  (dst_addr_i),
        .len_i       (len_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .spi_clk_o   (spi_clk_o),
        .spi_csn_o   (spi_csn_o),
        .spi_sdo_o   (spi_sdo_o),
        .spi_sdi_i   (spi_sdi_i),
        .mem_req_o   (mem_req_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_gnt_i   (mem_gnt_i)
    );

    always #5 clk = ~clk;

    // Flash content: 11 22 .. 88 at 0x000100, a fixed pattern elsewhere.
    function automatic logic [7:0] fbyte(input logic [23:0] a);
        if (a >= 24'h000100 && a < 24'h000108) return 8'h11 * 8'(a - 24'h0000FF);
        return a[7:0] ^ a[15:8] ^ 8'hA5;
    endfunction

    // Flash model: mode 0, samples SI on rising SCK, drives SO on falling SCK.
    int unsigned f_rise = 0, f_obit = 0;
    logic [7:0]  f_cmd = '0;
    logic [23:0] f_addr = '0;
    logic        csn_q = 1'b1, sck_q = 1'b0;

    always @(posedge spi_clk_o or negedge spi_clk_o or negedge spi_csn_o or posedge spi_csn_o) begin
        logic [7:0] b;
        if (!spi_csn_o && csn_q) begin
            f_rise = 0; f_obit = 0; f_cmd = '0; f_addr = '0;
        end else if (!spi_csn_o && spi_clk_o && !sck_q) begin
            if (f_rise < 8)       f_cmd  = {f_cmd[6:0], spi_sdo_o};
            else if (f_rise < 32) f_addr = {f_addr[22:0], spi_sdo_o};
            f_rise++;
        end else if (!spi_csn_o && !spi_clk_o && sck_q && f_rise >= 32 + DUMMY) begin
            b = fbyte(f_addr + 24'(f_obit / 8));
            spi_sdi_i = b[7 - (f_obit % 8)];
            f_obit++;
        end
        csn_q = spi_csn_o;
        sck_q = spi_clk_o;
    end

    typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;
    wr_t sb[$];

    int unsigned vectors = 0, miscompares = 0;
    int unsigned done_cnt = 0, csn_low_cnt = 0, req_cnt = 0, bp_cycles = 0;
    bit          bp_active = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle, observed on the falling clk edge.
    task automatic step();
        wr_t w;
        @(negedge clk);
        if (done_o === 1'b1)     done_cnt++;
        if (spi_csn_o === 1'b0)  csn_low_cnt++;
        if (mem_req_o === 1'b1)  req_cnt++;
        if (mem_req_o === 1'b1 && mem_gnt_i) begin
            check("write expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                w = sb.pop_front();
                check("wr addr", mem_addr_o, w.addr);
                check("wr data", mem_wdata_o, w.data);
            end
        end
        if (bp_active && mem_req_o === 1'b1 && !mem_gnt_i) begin
            bp_cycles++;
            check("bp addr", mem_addr_o, 32'h8000_0000);
            check("bp data", mem_wdata_o, 32'h4433_2211);
            check("bp sck low", 32'(spi_clk_o), 32'd0);
            check("bp csn low", 32'(spi_csn_o), 32'd0);
        end
    endtask

    task automatic push_expected(input logic [23:0] src, input logic [31:0] dst, input int unsigned len);
        for (int unsigned i = 0; i < len; i++) begin
            logic [23:0] s;
            wr_t w;
            s = src + 24'(4 * i);
            w.addr = dst + 32'(4 * i);
            w.data = {fbyte(s + 24'd3), fbyte(s + 24'd2), fbyte(s + 24'd1), fbyte(s)};
            sb.push_back(w);
        end
    endtask

    task automatic pulse_start(input logic [23:0] src, input logic [31:0] dst, input logic [15:0] len);
        @(posedge clk); #1;
        src_addr_i = src; dst_addr_i = dst; len_i = len; start_i = 1'b1;
        step();
        @(posedge clk); #1;
        start_i = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int unsigned budget);
        int unsigned snap = done_cnt;
        int unsigned n = 0;
        while (done_cnt == snap && n < budget) begin step(); n++; end
        check(tag, done_cnt - snap, 32'd1);
    endtask

    initial begin
        int unsigned d0, c0, r0, n;

        // Reset state
        step(); step();
        check("rst busy", 32'(busy_o), 32'd0);
        check("rst done", 32'(done_o), 32'd0);
        check("rst sck", 32'(spi_clk_o), 32'd0);
        check("rst csn", 32'(spi_csn_o), 32'd1);
        check("rst sdo", 32'(spi_sdo_o), 32'd0);
        check("rst req", 32'(mem_req_o), 32'd0);
        check("rst addr", mem_addr_o, 32'h0);
        check("rst wdata", mem_wdata_o, 32'h0);
        @(posedge clk); #1 rst_n = 1'b1;
        step();

        // Basic copy
        sb.push_back('{32'h8000_0000, 32'h4433_2211});
        sb.push_back('{32'h8000_0004, 32'h8877_6655});
        d0 = done_cnt;
        pulse_start(24'h000100, 32'h8000_0000, 16'd2);
        wait_done("basic done", 2000);
        repeat (10) step();
        check("basic cmd", 32'(f_cmd), 32'(EXP_CMD));
        check("basic sck rises", f_rise, 8 + 24 + DUMMY + 64);
        check("basic done pulses", done_cnt - d0, 32'd1);
        check("basic sb drained", sb.size(), 32'd0);

        // Backpressure on the first word
        sb.push_back('{32'h8000_0000, 32'h4433_2211});
        sb.push_back('{32'h8000_0004, 32'h8877_6655});
        @(posedge clk); #1 mem_gnt_i = 1'b0;
        bp_active = 1'b1;
        bp_cycles = 0;
        pulse_start(24'h000100, 32'h8000_0000, 16'd2);
        n = 0;
        while (mem_req_o !== 1'b1 && n < 1000) begin step(); n++; end
        check("bp req seen", 32'(mem_req_o), 32'd1);
        repeat (20) step();
        @(posedge clk); #1 mem_gnt_i = 1'b1;
        bp_active = 1'b0;
        wait_done("bp done", 2000);
        repeat (10) step();
        check("bp held cycles", 32'(bp_cycles >= 20), 32'd1);
        check("bp sb drained", sb.size(), 32'd0);

        // len = 0
        d0 = done_cnt; c0 = csn_low_cnt; r0 = req_cnt;
        pulse_start(24'h000100, 32'h8000_0000, 16'd0);
        step();
        check("len0 c1 done", 32'(done_o), 32'd0);
        check("len0 c1 busy", 32'(busy_o), 32'd1);
        step();
        check("len0 c2 done", 32'(done_o), 32'd1);
        check("len0 c2 busy", 32'(busy_o), 32'd0);
        step();
        check("len0 c3 done", 32'(done_o), 32'd0);
        repeat (10) step();
        check("len0 done pulses", done_cnt - d0, 32'd1);
        check("len0 csn low", csn_low_cnt - c0, 32'd0);
        check("len0 req", req_cnt - r0, 32'd0);

        // Reset during ADDR, then a clean rerun
        pulse_start(24'h000100, 32'h8000_0000, 16'd2);
        n = 0;
        while (f_rise < 12 && n < 1000) begin step(); n++; end
        check("mid reached addr", 32'(f_rise >= 12), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid rst csn", 32'(spi_csn_o), 32'd1);
        check("mid rst sck", 32'(spi_clk_o), 32'd0);
        check("mid rst busy", 32'(busy_o), 32'd0);
        check("mid rst req", 32'(mem_req_o), 32'd0);
        step(); step();
        @(posedge clk); #1 rst_n = 1'b1;
        step();
        sb.push_back('{32'h8000_0000, 32'h4433_2211});
        sb.push_back('{32'h8000_0004, 32'h8877_6655});
        pulse_start(24'h000100, 32'h8000_0000, 16'd2);
        wait_done("rerun done", 2000);
        repeat (10) step();
        check("rerun sck rises", f_rise, 8 + 24 + DUMMY + 64);
        check("rerun sb drained", sb.size(), 32'd0);

        // Start while busy is ignored; destination wraps past 2^32
        push_expected(24'h000200, 32'hFFFF_FFFC, 2);
        check("wrap exp addr1", sb[1].addr, 32'h0000_0000);
        d0 = done_cnt;
        pulse_start(24'h000200, 32'hFFFF_FFFC, 16'd2);
        repeat (50) step();
        check("busy mid", 32'(busy_o), 32'd1);
        pulse_start(24'h000000, 32'h0000_1000, 16'd5);
        wait_done("wrap done", 2000);
        repeat (400) step();
        check("wrap done pulses", done_cnt - d0, 32'd1);
        check("wrap sb drained", sb.size(), 32'd0);
        check("wrap idle busy", 32'(busy_o), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed no completion, expected summary before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
